// File: rtl/piso.sv
// ---------------------------------------------------------------------------
// piso -- parallel-in / serial-out shift register
//
// Purpose:
//   Captures a WIDTH-bit word on a load cycle and streams it out one bit per
//   clock on the following shift cycles.  Shifting moves data toward the out
//   bit and fills the vacated end with zeros, so once the word is exhausted
//   the output stays 0 until the next load (no recirculation).
//
// Parameters:
//   WIDTH      parallel data width in bits (>= 2)
//   MSB_FIRST  1 = stream in[WIDTH-1] first, 0 = stream in[0] first
//
// Ports:
//   clk    in   rising-edge clock, the only timing reference
//   reset  in   synchronous, active-high; clears the register to zero
//   mode   in   1 = parallel load of `in`, 0 = shift one position
//   in     in   WIDTH-bit parallel word, sampled only when mode = 1
//   out    out  serial bit, taken straight from the register's end bit
//
// Priority at each edge: reset, then load, then shift.  There is no
// handshake: every edge with mode = 0 and reset = 0 is a shift, and a load
// issued mid-stream silently discards whatever bits were still pending.
// ---------------------------------------------------------------------------
module piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    // Serial output end of the register: the bit that drives out.
    localparam int OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_sreg_next;

    // Shifted image of the register, built bit by bit.  Each bit takes its
    // neighbour on the side away from the out bit; the far end (the bit the
    // data is moving away from) is refilled with 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign w_shift[gi] = 1'b0;
                end else begin : g_move
                    assign w_shift[gi] = r_sreg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign w_shift[gi] = 1'b0;
                end else begin : g_move
                    assign w_shift[gi] = r_sreg[gi+1];
                end
            end
        end
    endgenerate

    // Load beats shift; reset is handled in the register process so that it
    // overrides both regardless of mode and in.
    always_comb begin
        w_sreg_next = w_shift;
        if (mode) begin
            w_sreg_next = in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg <= '0;
        end else begin
            r_sreg <= w_sreg_next;
        end
    end

    // Driven directly from the register so the first serial bit appears
    // right after the load edge, with no extra pipeline stage.
    assign out = r_sreg[OUT_IDX];

endmodule

// File: tb/tb_piso.sv
// ---------------------------------------------------------------------------
// tb_piso -- self-checking bench for piso
//
// Two instances share clock, reset and mode: a 4-bit MSB-first build and an
// 8-bit LSB-first build.  A reference model keeps, for each instance, the
// queue of bits still waiting to be emitted; the expected output is the head
// of that queue, or 0 once it is empty.
// ---------------------------------------------------------------------------
module tb_piso;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] in4 = '0;
    logic [7:0] in8 = '0;
    logic       out4;
    logic       out8;

    int checks = 0;
    int failures = 0;

    // Pending serial bits, head = bit currently on out.
    bit q4[$];
    bit q8[$];

    always #5 clk = ~clk;

    piso #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .in    (in4),
        .out   (out4)
    );

    piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .in    (in8),
        .out   (out8)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one edge's worth of inputs, advance the model, then compare both
    // outputs against the model.  e4/e8 >= 0 adds a hard-coded expectation.
    task automatic edge_step(input string tag, input logic r, input logic m,
                             input logic [3:0] d4, input logic [7:0] d8,
                             input int e4 = -1, input int e8 = -1);
        logic x4;
        logic x8;
        reset = r;
        mode  = m;
        in4   = d4;
        in8   = d8;
        @(posedge clk);
        #1;
        if (r) begin
            q4.delete();
            q8.delete();
        end else if (m) begin
            q4.delete();
            q8.delete();
            for (int i = 3; i >= 0; i--) q4.push_back(d4[i]);
            for (int i = 0; i < 8; i++) q8.push_back(d8[i]);
        end else begin
            if (q4.size() > 0) void'(q4.pop_front());
            if (q8.size() > 0) void'(q8.pop_front());
        end
        x4 = (q4.size() > 0) ? q4[0] : 1'b0;
        x8 = (q8.size() > 0) ? q8[0] : 1'b0;
        check({tag, "/msb4"}, out4, x4);
        check({tag, "/lsb8"}, out8, x8);
        if (e4 >= 0) check({tag, "/msb4_const"}, out4, e4[0]);
        if (e8 >= 0) check({tag, "/lsb8_const"}, out8, e8[0]);
        $display("step %-10s reset=%b mode=%b in4=%h in8=%h -> out4=%b out8=%b",
                 tag, r, m, d4, d8, out4, out8);
    endtask

    initial begin
        int e_lsb[8];
        logic r;
        logic m;

        // Reset with load asserted and all-ones data: reset must win.
        edge_step("reset", 1'b1, 1'b1, 4'b1111, 8'hFF, 0, 0);

        // Load 1011 and stream it out, then confirm zero fill.
        edge_step("ld1011", 1'b0, 1'b1, 4'b1011, 8'h00, 1);
        edge_step("sh1", 1'b0, 1'b0, 4'h0, 8'h00, 0);
        edge_step("sh2", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("sh3", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("sh4", 1'b0, 1'b0, 4'h0, 8'h00, 0);
        edge_step("sh5", 1'b0, 1'b0, 4'hF, 8'hFF, 0);

        // Load 1100.
        edge_step("ld1100", 1'b0, 1'b1, 4'b1100, 8'h00, 1);
        edge_step("sh1", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("sh2", 1'b0, 1'b0, 4'h0, 8'h00, 0);
        edge_step("sh3", 1'b0, 1'b0, 4'h0, 8'h00, 0);
        edge_step("sh4", 1'b0, 1'b0, 4'h0, 8'h00, 0);

        // Mid-stream reload discards the rest of 1011.
        edge_step("ld1011", 1'b0, 1'b1, 4'b1011, 8'h00, 1);
        edge_step("sh1", 1'b0, 1'b0, 4'h0, 8'h00, 0);
        edge_step("sh2", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("ld0111", 1'b0, 1'b1, 4'b0111, 8'h00, 0);
        edge_step("sh1", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("sh2", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("sh3", 1'b0, 1'b0, 4'h0, 8'h00, 1);
        edge_step("sh4", 1'b0, 1'b0, 4'h0, 8'h00, 0);

        // Reset during a stream aborts it.
        edge_step("ld1111", 1'b0, 1'b1, 4'b1111, 8'hFF, 1, 1);
        edge_step("sh1", 1'b0, 1'b0, 4'h0, 8'h00, 1, 1);
        edge_step("rst", 1'b1, 1'b0, 4'h0, 8'h00, 0, 0);
        edge_step("sh1", 1'b0, 1'b0, 4'h0, 8'h00, 0, 0);
        edge_step("sh2", 1'b0, 1'b0, 4'h0, 8'h00, 0, 0);

        // Back-to-back loads track the first serial bit of each word.
        edge_step("bb1", 1'b0, 1'b1, 4'b1000, 8'h01, 1, 1);
        edge_step("bb2", 1'b0, 1'b1, 4'b0111, 8'hFE, 0, 0);
        edge_step("bb3", 1'b0, 1'b1, 4'b1010, 8'h55, 1, 1);

        // LSB-first 8-bit build: A5 streams as 1,0,1,0,0,1,0,1, then 0.
        e_lsb = '{1, 0, 1, 0, 0, 1, 0, 1};
        edge_step("ldA5", 1'b0, 1'b1, 4'h0, 8'hA5, 0, e_lsb[0]);
        for (int i = 1; i < 8; i++)
            edge_step("shA5", 1'b0, 1'b0, 4'h0, 8'h00, 0, e_lsb[i]);
        edge_step("shA5end", 1'b0, 1'b0, 4'h0, 8'h00, 0, 0);

        // Randomized traffic checked against the queue model.
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 15) == 0);
            m = ($urandom_range(0, 3) == 0);
            edge_step("rand", r, m, 4'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
